wb_commit_unit: RTL and testbench



---
 rtl/wb_commit_unit.sv | 123 ++++++++++++
 tb/tb_wb_commit_unit.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_commit_unit.sv
// Writeback/commit stage: register-file write port, one-entry bypass of the
// last committed write, retired-instruction counter and the halt sequence
// (drain, dcache flush handshake, sticky halt).
module wb_commit_unit #(
    parameter int CNT_W         = 32,
    parameter int FLUSH_TIMEOUT = 1023
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             advance,
    input  logic             valid_wb,
    input  logic             regWr_wb,
    input  logic [4:0]       wsel_wb,
    input  logic [1:0]       MemToReg_wb,
    input  logic [31:0]      portO_wb,
    input  logic [31:0]      dmemload_wb,
    input  logic [31:0]      luiValue_wb,
    input  logic [31:0]      pcp4_wb,
    input  logic             halt_wb,
    input  logic             flush_done,
    output logic             rf_WEN,
    output logic [4:0]       rf_wsel,
    output logic [31:0]      rf_wdat,
    output logic             fwd_valid,
    output logic [4:0]       fwd_sel,
    output logic [31:0]      fwd_dat,
    output logic             flush_req,
    output logic             halt,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        HALTED
    } commitState_t;

    // Wide enough to hold FLUSH_TIMEOUT itself (the value reached on the last DRAIN cycle).
    localparam int TO_W = (FLUSH_TIMEOUT < 1) ? 1 : $clog2(FLUSH_TIMEOUT + 1);

    commitState_t    state, nextState;
    logic [TO_W-1:0] timeoutCnt;
    logic            commit;
    logic            writeEn;
    logic            timeoutHit;

    // Commit qualification and register-file write enable.
    always_comb begin
        commit  = advance & valid_wb & (state == RUN);
        // NOTE: the enable is gated by RST so nothing reaches the register file
        // during the reset cycle, even though the flops ignore it anyway.
        writeEn = commit & regWr_wb & (wsel_wb != 5'd0) & ~halt_wb & ~RST;
    end

    // Write-data select; the data and select paths are left unconditioned.
    always_comb begin
        // NOTE: default first so every path assigns rf_wdat and no latch is inferred.
        rf_wdat = portO_wb;
        unique case (MemToReg_wb)
            2'd0: rf_wdat = portO_wb;
            2'd1: rf_wdat = dmemload_wb;
            2'd2: rf_wdat = luiValue_wb;
            2'd3: rf_wdat = pcp4_wb;
        endcase
    end

    assign rf_WEN  = writeEn;
    assign rf_wsel = wsel_wb;

    // Halt-sequence state register.
    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (RST) state <= RUN;
        else     state <= nextState;
    end

    // Timeout on the flush handshake: last DRAIN cycle is the FLUSH_TIMEOUT-th.
    assign timeoutHit = (timeoutCnt == TO_W'(FLUSH_TIMEOUT - 1));

    // Next-state logic for RUN -> DRAIN -> HALTED.
    always_comb begin
        nextState = state;
        unique case (state)
            RUN:     if (commit && halt_wb) nextState = DRAIN;
            DRAIN:   if (flush_done || timeoutHit) nextState = HALTED;
            HALTED:  nextState = HALTED;
            default: nextState = RUN;
        endcase
    end

    // Flush-wait counter: held at zero outside DRAIN, so it starts at zero on entry.
    always_ff @(posedge CLK) begin
        if (RST || state != DRAIN) timeoutCnt <= '0;
        else                       timeoutCnt <= timeoutCnt + TO_W'(1);
    end

    // Both outputs decode the state register directly, so they are glitch-free.
    assign flush_req = (state == DRAIN);
    assign halt      = (state == HALTED);

    // Bypass entry: captures the last register-file write and stays valid.
    always_ff @(posedge CLK) begin
        // NOTE: these are a handful of flops, not a RAM, so all of them are
        // reset to give the decode stage a known entry after reset.
        if (RST) begin
            fwd_valid <= 1'b0;
            fwd_sel   <= 5'd0;
            fwd_dat   <= 32'd0;
        end else if (writeEn) begin
            fwd_valid <= 1'b1;
            fwd_sel   <= rf_wsel;
            fwd_dat   <= rf_wdat;
        end
    end

    // Retired-instruction counter, saturating; HALT itself is not counted.
    always_ff @(posedge CLK) begin
        if (RST)                                       retired <= '0;
        else if (commit && !halt_wb && retired != '1)  retired <= retired + CNT_W'(1);
    end

endmodule

// File: tb/tb_wb_commit_unit.sv
// Directed self-checking bench for wb_commit_unit (small counter and timeout).
module tb_wb_commit_unit;

    localparam int CNT_W         = 4;
    localparam int FLUSH_TIMEOUT = 6;

    localparam logic [31:0] PORTO = 32'h0000_1234;
    localparam logic [31:0] DLOAD = 32'hAAAA_0001;
    localparam logic [31:0] LUI   = 32'h5555_0000;
    localparam logic [31:0] PCP4  = 32'h0040_0004;

    logic             CLK;
    logic             RST;
    logic             advance;
    logic             valid_wb;
    logic             regWr_wb;
    logic [4:0]       wsel_wb;
    logic [1:0]       MemToReg_wb;
    logic [31:0]      portO_wb;
    logic [31:0]      dmemload_wb;
    logic [31:0]      luiValue_wb;
    logic [31:0]      pcp4_wb;
    logic             halt_wb;
    logic             flush_done;
    logic             rf_WEN;
    logic [4:0]       rf_wsel;
    logic [31:0]      rf_wdat;
    logic             fwd_valid;
    logic [4:0]       fwd_sel;
    logic [31:0]      fwd_dat;
    logic             flush_req;
    logic             halt;
    logic [CNT_W-1:0] retired;

    int checkCount = 0;
    int passCount  = 0;

    wb_commit_unit #(
        .CNT_W        (CNT_W),
        .FLUSH_TIMEOUT(FLUSH_TIMEOUT)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .advance    (advance),
        .valid_wb   (valid_wb),
        .regWr_wb   (regWr_wb),
        .wsel_wb    (wsel_wb),
        .MemToReg_wb(MemToReg_wb),
        .portO_wb   (portO_wb),
        .dmemload_wb(dmemload_wb),
        .luiValue_wb(luiValue_wb),
        .pcp4_wb    (pcp4_wb),
        .halt_wb    (halt_wb),
        .flush_done (flush_done),
        .rf_WEN     (rf_WEN),
        .rf_wsel    (rf_wsel),
        .rf_wdat    (rf_wdat),
        .fwd_valid  (fwd_valid),
        .fwd_sel    (fwd_sel),
        .fwd_dat    (fwd_dat),
        .flush_req  (flush_req),
        .halt       (halt),
        .retired    (retired)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic adv, input logic vld, input logic rw,
                         input logic [4:0] ws, input logic [1:0] m2r, input logic hlt);
        advance     = adv;
        valid_wb    = vld;
        regWr_wb    = rw;
        wsel_wb     = ws;
        MemToReg_wb = m2r;
        halt_wb     = hlt;
        #1;
    endtask

    task automatic doReset();
        RST = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 5'd0, 2'd0, 1'b0);
        step();
        RST = 1'b0;
    endtask

    initial begin
        RST         = 1'b1;
        flush_done  = 1'b0;
        portO_wb    = PORTO;
        dmemload_wb = DLOAD;
        luiValue_wb = LUI;
        pcp4_wb     = PCP4;
        drive(1'b0, 1'b0, 1'b0, 5'd0, 2'd0, 1'b0);
        step();

        // Write enable held low during reset even with a full write request.
        drive(1'b1, 1'b1, 1'b1, 5'd8, 2'd0, 1'b0);
        check("wen_in_reset", rf_WEN, 0);
        step();
        RST = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 5'd0, 2'd0, 1'b0);
        check("rst_fwd_valid", fwd_valid, 0);
        check("rst_fwd_sel", fwd_sel, 0);
        check("rst_fwd_dat", fwd_dat, 0);
        check("rst_retired", retired, 0);
        check("rst_flush_req", flush_req, 0);
        check("rst_halt", halt, 0);

        // ALU write to $8.
        drive(1'b1, 1'b1, 1'b1, 5'd8, 2'd0, 1'b0);
        check("alu_wen", rf_WEN, 1);
        check("alu_wsel", rf_wsel, 8);
        check("alu_wdat", rf_wdat, PORTO);
        step();
        check("alu_fwd_valid", fwd_valid, 1);
        check("alu_fwd_sel", fwd_sel, 8);
        check("alu_fwd_dat", fwd_dat, PORTO);
        check("alu_retired", retired, 1);

        // Remaining mux legs.
        drive(1'b1, 1'b1, 1'b1, 5'd9, 2'd1, 1'b0);
        check("mux1_wdat", rf_wdat, DLOAD);
        step();
        check("mux1_fwd_dat", fwd_dat, DLOAD);
        check("mux1_fwd_sel", fwd_sel, 9);
        drive(1'b1, 1'b1, 1'b1, 5'd10, 2'd2, 1'b0);
        check("mux2_wdat", rf_wdat, LUI);
        step();
        check("mux2_fwd_dat", fwd_dat, LUI);
        drive(1'b1, 1'b1, 1'b1, 5'd31, 2'd3, 1'b0);
        check("mux3_wdat", rf_wdat, PCP4);
        step();
        check("mux3_fwd_dat", fwd_dat, PCP4);
        check("mux3_fwd_sel", fwd_sel, 31);
        check("mux3_retired", retired, 4);

        // Write to $0: suppressed, bypass held, still retired.
        drive(1'b1, 1'b1, 1'b1, 5'd0, 2'd0, 1'b0);
        check("r0_wen", rf_WEN, 0);
        step();
        check("r0_fwd_sel", fwd_sel, 31);
        check("r0_fwd_dat", fwd_dat, PCP4);
        check("r0_retired", retired, 5);

        // Stalls and bubbles with regWr asserted.
        for (int i = 0; i < 5; i++) begin
            if (i % 2 == 0) drive(1'b0, 1'b1, 1'b1, 5'd12, 2'd0, 1'b0);
            else            drive(1'b1, 1'b0, 1'b1, 5'd12, 2'd0, 1'b0);
            check("stall_wen", rf_WEN, 0);
            step();
            check("stall_retired", retired, 5);
        end
        check("stall_fwd_sel", fwd_sel, 31);

        // HALT with regWr=1 and an early flush_done that must be ignored.
        flush_done = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 5'd8, 2'd0, 1'b1);
        check("halt_commit_wen", rf_WEN, 0);
        check("halt_commit_freq", flush_req, 0);
        step();
        for (int i = 1; i <= 4; i++) begin
            flush_done = (i == 4);
            drive(1'b1, 1'b1, 1'b1, 5'd12, 2'd0, 1'b0);
            check("drain_flush_req", flush_req, 1);
            check("drain_halt", halt, 0);
            check("drain_wen", rf_WEN, 0);
            step();
        end
        flush_done = 1'b0;
        check("halted_flush_req", flush_req, 0);
        check("halted_halt", halt, 1);
        check("halted_retired", retired, 5);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 1'b1, 5'd12, 2'd0, 1'b0);
            check("halted_wen", rf_WEN, 0);
            step();
            check("halted_sticky", halt, 1);
            check("halted_no_count", retired, 5);
            check("halted_no_fwd", fwd_sel, 31);
        end

        // Timeout path: flush_done never arrives.
        doReset();
        check("rst2_halt", halt, 0);
        check("rst2_retired", retired, 0);
        drive(1'b1, 1'b1, 1'b0, 5'd0, 2'd0, 1'b1);
        step();
        drive(1'b0, 1'b0, 1'b0, 5'd0, 2'd0, 1'b0);
        for (int i = 0; i < FLUSH_TIMEOUT; i++) begin
            check("to_flush_req", flush_req, 1);
            check("to_halt", halt, 0);
            step();
        end
        check("to_expired_freq", flush_req, 0);
        check("to_expired_halt", halt, 1);

        // Reset in the middle of DRAIN.
        doReset();
        drive(1'b1, 1'b1, 1'b1, 5'd5, 2'd0, 1'b0);
        step();
        drive(1'b1, 1'b1, 1'b0, 5'd0, 2'd0, 1'b1);
        step();
        drive(1'b0, 1'b0, 1'b0, 5'd0, 2'd0, 1'b0);
        step();
        check("mid_drain_freq", flush_req, 1);
        check("mid_drain_retired", retired, 1);
        RST = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 5'd6, 2'd0, 1'b0);
        check("mid_rst_wen", rf_WEN, 0);
        step();
        RST = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 5'd0, 2'd0, 1'b0);
        check("mid_rst_freq", flush_req, 0);
        check("mid_rst_halt", halt, 0);
        check("mid_rst_retired", retired, 0);
        check("mid_rst_fwd_valid", fwd_valid, 0);
        check("mid_rst_fwd_sel", fwd_sel, 0);
        check("mid_rst_fwd_dat", fwd_dat, 0);
        drive(1'b1, 1'b1, 1'b1, 5'd7, 2'd0, 1'b0);
        check("mid_rst_run_wen", rf_WEN, 1);

        // Saturation of the 4-bit counter over 20 commits.
        doReset();
        for (int k = 1; k <= 20; k++) begin
            drive(1'b1, 1'b1, 1'b0, 5'd3, 2'd0, 1'b0);
            step();
            check("sat_retired", retired, (k > 15) ? 32'd15 : 32'(k));
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
